// File: rtl/halut_tree_encoder.sv
// Balanced binary decision-tree encoder: walks one level per clock over an FP16 vector
// and produces a DEPTH-bit prototype index (MSB = root decision) for the halut LUT stage.
module halut_tree_encoder #(
  parameter  int DEPTH = 4,
  parameter  int DIM   = 16,
  localparam int NODES = (1 << DEPTH) - 1,
  localparam int DIM_W = $clog2(DIM)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_we_i,
  input  logic [DEPTH-1:0]     cfg_addr_i,
  input  logic [DIM_W-1:0]     cfg_dim_i,
  input  logic [15:0]          cfg_thr_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [16*DIM-1:0]    in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DEPTH-1:0]     out_idx_o
);

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

  state_t               state_reg, state_next;
  logic [DEPTH-1:0]     node_reg, node_next;
  logic [DEPTH-1:0]     level_reg, level_next;
  logic [DEPTH-1:0]     out_idx_reg, out_idx_next;
  logic [16*DIM-1:0]    vec_reg, vec_next;

  logic [DIM_W-1:0]     dim_reg [NODES];
  logic [15:0]          thr_reg [NODES];
  logic [15:0]          elem [DIM];

  logic                 cfg_apply;
  logic                 d;
  logic [DIM_W-1:0]     dim_sel;
  logic [15:0]          x_sel, thr_sel;
  logic [DEPTH:0]       child;

  // Sign-magnitude total order on raw patterns; +0 ranks above -0, identical gives 0.
  function automatic logic fp16_gt(input logic [15:0] a, input logic [15:0] b);
    if (a[15] != b[15])
      return b[15];
    else if (!a[15])
      return a[14:0] > b[14:0];
    else
      return a[14:0] < b[14:0];
  endfunction

  assign cfg_apply = (state_reg == IDLE) && cfg_we_i && (cfg_addr_i != DEPTH'(NODES));

  for (genvar gi = 0; gi < DIM; gi++) begin : g_elem
    assign elem[gi] = vec_reg[16*gi +: 16];
  end

  for (genvar gi = 0; gi < NODES; gi++) begin : g_node
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        dim_reg[gi] <= '0;
        thr_reg[gi] <= '0;
      end else if (cfg_apply && (cfg_addr_i == DEPTH'(gi))) begin
        dim_reg[gi] <= cfg_dim_i;
        thr_reg[gi] <= cfg_thr_i;
      end
    end
  end

  assign dim_sel = dim_reg[node_reg];
  assign thr_sel = thr_reg[node_reg];
  assign x_sel   = elem[dim_sel];
  assign d       = fp16_gt(x_sel, thr_sel);
  // Heap-order child: 2*node+1+d, one bit wider so the leaf level never overflows.
  assign child   = {node_reg, 1'b1} + {{DEPTH{1'b0}}, d};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      node_reg    <= '0;
      level_reg   <= '0;
      out_idx_reg <= '0;
      vec_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      node_reg    <= node_next;
      level_reg   <= level_next;
      out_idx_reg <= out_idx_next;
      vec_reg     <= vec_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    node_next    = node_reg;
    level_next   = level_reg;
    out_idx_next = out_idx_reg;
    vec_next     = vec_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid_i) begin
          vec_next   = in_data_i;
          node_next  = '0;
          level_next = '0;
          state_next = WALK;
        end
      end
      WALK: begin
        node_next  = child[DEPTH-1:0];
        level_next = level_reg + 1'b1;
        if (level_reg == DEPTH'(DEPTH - 1)) begin
          out_idx_next = DEPTH'(child - (DEPTH+1)'(NODES));
          state_next   = DONE;
        end
      end
      DONE: begin
        if (out_ready_i)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready_o  = (state_reg == IDLE);
  assign out_valid_o = (state_reg == DONE);
  assign out_idx_o   = out_idx_reg;

endmodule

// File: tb/tb_halut_tree_encoder.sv
// Scoreboard bench for halut_tree_encoder: directed corner cases plus randomized tables
// and vectors checked against a heap-walk reference model.
module tb_halut_tree_encoder;
  localparam int DEPTH = 4;
  localparam int DIM   = 16;
  localparam int NODES = 15;

  logic           clk = 1'b0;
  logic           rst_i;
  logic           cfg_we_i;
  logic [3:0]     cfg_addr_i;
  logic [3:0]     cfg_dim_i;
  logic [15:0]    cfg_thr_i;
  logic           in_valid_i;
  logic           in_ready_o;
  logic [255:0]   in_data_i;
  logic           out_valid_o;
  logic           out_ready_i;
  logic [3:0]     out_idx_o;

  halut_tree_encoder #(.DEPTH(DEPTH), .DIM(DIM)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_dim_i(cfg_dim_i), .cfg_thr_i(cfg_thr_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_idx_o(out_idx_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] idx;
    int         cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          m_dim [NODES];
  logic [15:0] m_thr [NODES];

  always @(posedge clk) cycle <= cycle + 1;

  // Ordering key: negatives map below every non-negative, with -0 strictly under +0.
  function automatic int key(input logic [15:0] h);
    int mag;
    mag = int'(h[14:0]);
    return h[15] ? (-mag - 1) : mag;
  endfunction

  function automatic logic [3:0] model_idx(input logic [255:0] v);
    int node, idx, dd;
    logic [15:0] x;
    node = 0;
    idx  = 0;
    for (int l = 0; l < DEPTH; l++) begin
      x    = v[16*m_dim[node] +: 16];
      dd   = (key(x) > key(m_thr[node])) ? 1 : 0;
      idx  = idx * 2 + dd;
      node = 2 * node + 1 + dd;
    end
    return 4'(idx);
  endfunction

  function automatic logic [255:0] vec1(input int k, input logic [15:0] val);
    logic [255:0] v;
    v = '0;
    v[16*k +: 16] = val;
    return v;
  endfunction

  function automatic logic [15:0] rand_h();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'h8000;
      2:       return m_thr[$urandom_range(0, NODES-1)];
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int n = 0; n < NODES; n++) begin
      m_dim[n] = 0;
      m_thr[n] = 16'h0000;
    end
  endtask

  task automatic cfg_write(input int addr, input int dim, input logic [15:0] thr, input bit applies);
    cfg_we_i = 1'b1; cfg_addr_i = 4'(addr); cfg_dim_i = 4'(dim); cfg_thr_i = thr;
    tick();
    cfg_we_i = 1'b0;
    if (applies && addr < NODES) begin
      m_dim[addr] = dim;
      m_thr[addr] = thr;
    end
  endtask

  task automatic set_all(input int dim, input logic [15:0] thr);
    for (int n = 0; n < NODES; n++) cfg_write(n, dim, thr, 1'b1);
  endtask

  task automatic send(input logic [255:0] v, input logic [3:0] e);
    int g;
    g = 0;
    while (!in_ready_o && g < 50) begin tick(); g++; end
    check("in_ready_wait", 16'(in_ready_o), 16'h1);
    in_valid_i = 1'b1;
    in_data_i  = v;
    tick();
    exp_q.push_back('{e, cycle});
    in_valid_i = 1'b0;
    in_data_i  = {8{$urandom}};
  endtask

  task automatic finish_run(input int stall);
    int g;
    g = 0;
    out_ready_i = (stall == 0);
    while (!out_valid_o && g < 20) begin tick(); g++; end
    check("out_valid_wait", 16'(out_valid_o), 16'h1);
    repeat (stall) tick();
    out_ready_i = 1'b1;
    tick();
    check("back_to_idle", 16'(in_ready_o), 16'h1);
  endtask

  // Monitor: every rising out_valid_o pops one expectation and checks index and latency.
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (rst_i) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid_o && !prev_v) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output got=%h want=none", out_idx_o);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (out_idx_o !== e.idx) begin
            errors++;
            $display("FAIL out_idx got=%h want=%h", out_idx_o, e.idx);
          end
          checks++;
          if (cycle - e.cyc != DEPTH) begin
            errors++;
            $display("FAIL latency got=%0d want=%0d", cycle - e.cyc, DEPTH);
          end
        end
      end
      prev_v = out_valid_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] v;
    logic [3:0]   e;
    rst_i = 1'b1; cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_dim_i = '0; cfg_thr_i = '0;
    in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b1;
    clear_model();
    repeat (3) tick();
    check("rst_in_ready", 16'(in_ready_o), 16'h1);
    check("rst_out_valid", 16'(out_valid_o), 16'h0);
    check("rst_out_idx", 16'(out_idx_o), 16'h0);
    rst_i = 1'b0;
    tick();

    // Empty table after reset: dim 0, thr +0 everywhere.
    send(vec1(0, 16'h3C00), 4'hF); finish_run(0);
    send(vec1(0, 16'hBC00), 4'h0); finish_run(0);

    set_all(2, 16'h4000);
    send(vec1(2, 16'h4000), 4'h0); finish_run(0);
    set_all(2, 16'h0000);
    send(vec1(2, 16'h8000), 4'h0); finish_run(0);
    set_all(2, 16'h8000);
    send(vec1(2, 16'h0000), 4'hF); finish_run(1);

    set_all(5, 16'hC000);
    send(vec1(5, 16'hBC00), 4'hF); finish_run(0);
    send(vec1(5, 16'hC200), 4'h0); finish_run(2);

    // Backpressure with ignored input pulses and a dropped root write.
    set_all(0, 16'h0000);
    send(vec1(0, 16'h3C00), 4'hF);
    out_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin
        int g;
        g = 0;
        while (!out_valid_o && g < 20) begin tick(); g++; end
      end
      in_valid_i = i[0];
      in_data_i  = {8{$urandom}};
      cfg_we_i = (i == 3); cfg_addr_i = 4'd0; cfg_dim_i = 4'd0; cfg_thr_i = 16'h7C00;
      tick();
      in_valid_i = 1'b0; cfg_we_i = 1'b0;
      check("bp_valid", 16'(out_valid_o), 16'h1);
      check("bp_idx", 16'(out_idx_o), 16'hF);
      check("bp_in_ready", 16'(in_ready_o), 16'h0);
    end
    out_ready_i = 1'b1;
    tick();
    check("idx_kept", 16'(out_idx_o), 16'hF);
    send(vec1(0, 16'h3C00), 4'hF); finish_run(0);

    // Write on the accept edge is used by that walk; NODES address is dropped.
    cfg_write(15, 0, 16'h7C00, 1'b1);
    cfg_we_i = 1'b1; cfg_addr_i = 4'd0; cfg_dim_i = 4'd0; cfg_thr_i = 16'h7C00;
    m_dim[0] = 0; m_thr[0] = 16'h7C00;
    send(vec1(0, 16'h3C00), 4'h7);
    cfg_we_i = 1'b0;
    finish_run(0);

    // Mixed path from a freshly reset table.
    rst_i = 1'b1; tick(); rst_i = 1'b0; clear_model(); tick();
    cfg_write(0, 1, 16'h0000, 1'b1);
    cfg_write(2, 3, 16'h4200, 1'b1);
    cfg_write(5, 0, 16'hBC00, 1'b1);
    cfg_write(12, 7, 16'h3800, 1'b1);
    v = '0;
    v[16*1 +: 16] = 16'h3C00;
    v[16*3 +: 16] = 16'h4000;
    v[16*0 +: 16] = 16'h0000;
    v[16*7 +: 16] = 16'h3800;
    send(v, 4'hA); finish_run(0);

    // Reset at level 2 discards the walk and the table.
    send(vec1(0, 16'h3C00), 4'h0);
    tick(); tick();
    rst_i = 1'b1;
    #1;
    check("rst_mid_valid", 16'(out_valid_o), 16'h0);
    check("rst_mid_ready", 16'(in_ready_o), 16'h1);
    exp_q.delete();
    clear_model();
    tick();
    rst_i = 1'b0;
    tick();
    send(vec1(0, 16'h3C00), 4'hF); finish_run(0);

    // Randomized tables and vectors against the reference model.
    for (int r = 0; r < 6; r++) begin
      for (int n = 0; n < NODES; n++) cfg_write(n, int'($urandom_range(0, DIM-1)), rand_h(), 1'b1);
      cfg_write(15, int'($urandom_range(0, DIM-1)), 16'($urandom), 1'b1);
      for (int t = 0; t < 8; t++) begin
        for (int k = 0; k < DIM; k++) v[16*k +: 16] = rand_h();
        e = model_idx(v);
        send(v, e);
        finish_run(int'($urandom_range(0, 2)));
      end
    end

    tick(); tick();
    check("queue_empty", 16'(exp_q.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/halut_tree_encoder.md
Name: halut_tree_encoder

Overview:
- Walks one balanced binary decision tree over an FP16 input vector, one level per clock, and emits a DEPTH-bit prototype index.
- At each node it selects one vector element and compares it against that node's FP16 threshold, using the team's FP16 strict-greater comparison stage.
- Sits upstream of the LUT-read/accumulate stage in the halut matmul datapath.
- The node table is loaded by software through a simple write port.

Parameters:
- DEPTH, 4, tree levels; number of nodes NODES = 2^DEPTH-1; index width = DEPTH.
- DIM, 16, FP16 elements per input vector; must be a power of 2; DIM_W = $clog2(DIM).

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- cfg_we_i  in  1  node-table write strobe.
- cfg_addr_i  in  DEPTH  node number, heap order, 0 = root; value NODES is ignored.
- cfg_dim_i  in  DIM_W  element index to test at this node.
- cfg_thr_i  in  16  FP16 threshold for this node.
- in_valid_i  in  1  input vector valid.
- in_ready_o  out  1  encoder can accept a vector.
- in_data_i  in  16*DIM  vector; element k = bits [16k+15:16k].
- out_valid_o  out  1  index valid.
- out_ready_i  in  1  consumer accepts index.
- out_idx_o  out  DEPTH  prototype index.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; in_ready_o=1; out_valid_o=0; out_idx_o=0; node=0; level=0.
  - Every table entry cleared to dim=0, thr=0x0000; latched vector cleared.
- Comparison semantics (decision bit d = x > thr, strict):
  - Sign-magnitude total order on the raw 16-bit patterns.
  - Differing signs: positive wins, so +0 (0x0000) > -0 (0x8000).
  - Both positive: larger {exp,mant} wins. Both negative: smaller {exp,mant} wins.
  - Bit-identical operands give d=0.
  - NaN/Inf/subnormals get no special handling; they are ordered by bit pattern as above.
- State IDLE:
  - in_ready_o=1.
  - On an in_valid_i & in_ready_o edge: latch in_data_i, node=0, level=0, go to WALK.
- State WALK:
  - in_ready_o=0.
  - Each edge: d = x[table[node].dim] > table[node].thr; node <= 2*node+1+d; level <= level+1.
  - On the edge where level==DEPTH-1: out_idx_o <= (2*node+1+d)-NODES, out_valid_o <= 1, go to DONE.
  - out_idx_o MSB is the root decision and LSB is the leaf-level decision (1 = right/greater).
- State DONE:
  - out_valid_o=1; out_idx_o held stable.
  - On an out_valid_o & out_ready_i edge: out_valid_o <= 0, go to IDLE.
  - out_idx_o keeps its last value after the handshake.
- Latency: out_valid_o rises exactly DEPTH cycles after the input handshake edge.
- Throughput: one vector per DEPTH+2 cycles minimum; there is no overlap between successive vectors.
- Config writes:
  - Applied only in IDLE; writes in WALK or DONE are silently dropped.
  - A write on the same edge as an input handshake is applied and is used by that walk.
  - Writes with cfg_addr_i==NODES are dropped.
- in_valid_i outside IDLE is ignored. in_data_i changes after the handshake do not affect the walk in progress.
- Reset mid-WALK or mid-DONE: the result is discarded and all state returns to reset values, including the table.

Test Plan:
- Reset with no writes -> in_ready_o=1, out_valid_o=0, out_idx_o=0.
- Sign extremes, all nodes dim=0, thr=0x0000:
  - x[0]=0x3C00 (1.0) -> out_idx_o=0xF exactly 4 cycles after accept.
  - x[0]=0xBC00 (-1.0) -> out_idx_o=0x0.
- Equality and signed zero, all nodes dim=2:
  - thr=0x4000, x[2]=0x4000 -> 0x0.
  - thr=0x0000, x[2]=0x8000 -> 0x0.
  - thr=0x8000, x[2]=0x0000 -> 0xF.
- Negative ordering, all nodes dim=5, thr=0xC000 (-2):
  - x[5]=0xBC00 (-1) -> 0xF.
  - x[5]=0xC200 (-3) -> 0x0.
- Mixed path:
  - Table: root dim1 thr 0x0000; node2 dim3 thr 0x4200; node5 dim0 thr 0xBC00; node12 dim7 thr 0x3800.
  - Vector: x1=0x3C00, x3=0x4000, x0=0x0000, x7=0x3800.
  - Result: decisions 1,0,1,0 -> out_idx_o=0xA.
- Backpressure and drop rules, DONE held with out_ready_i=0 for 10 cycles:
  - out_valid_o and out_idx_o stay stable; in_ready_o=0.
  - in_valid_i pulses are ignored.
  - A cfg write to the root is dropped; a following run confirms the old table.
- Reset mid-walk: assert rst_i at level 2 -> out_valid_o=0, in_ready_o=1 at once; the next run with an empty table gives 0xF for x[0]=0x3C00.
